// File: rtl/liteic_pkg.sv
// Shared constants and types for the liteic crossbar nodes.
package liteic_pkg;

  localparam int IC_NUM_MASTER_SLOTS = 4;
  localparam int IC_ARADDR_WIDTH     = 32;
  localparam int IC_RESP_WIDTH       = 2;
  // R payload is {r_data, r_resp}
  localparam int IC_RDATA_WIDTH      = 32 + IC_RESP_WIDTH;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_node_state_t;

  // Index width that stays legal for a single-requester column.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite read channels (AR/R) between a crossbar slave node and its slave port.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = liteic_pkg::IC_ARADDR_WIDTH,
  parameter int DATA_WIDTH = liteic_pkg::IC_RDATA_WIDTH - liteic_pkg::IC_RESP_WIDTH
);
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

  modport mst (
    output ar_valid, ar_addr, r_ready,
    input  ar_ready, r_valid, r_data, r_resp
  );

  modport slv (
    input  ar_valid, ar_addr, r_ready,
    output ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/liteic_priority_cd.sv
// One-hot to binary converter; the lowest set bit wins if the input is not one-hot.
module liteic_priority_cd
  import liteic_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot_i,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (onehot_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/liteic_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping.
module liteic_rr_arbiter
  import liteic_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic             found;
  int               pos;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    pos     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (!found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  liteic_priority_cd #(
    .WIDTH (NUM_REQ)
  ) u_grant_cd (
    .onehot_i (grant_o),
    .idx_o    (idx_o)
  );

endmodule

// File: rtl/liteic_slave_node_read.sv
// Slave-side read node: arbitrates master AR requests onto one AXI-Lite port
// and steers the single outstanding R beat back to the granted master.
module liteic_slave_node_read
  import liteic_pkg::*;
#(
  parameter int                     NUM_MASTERS  = IC_NUM_MASTER_SLOTS,
  parameter logic [NUM_MASTERS-1:0] CONNECTIVITY = '1,
  parameter int                     ADDR_WIDTH   = IC_ARADDR_WIDTH,
  parameter int                     RDATA_WIDTH  = IC_RDATA_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  axi_lite_if.mst                slv_axil,
  input  logic [NUM_MASTERS-1:0] cbar_reqst_val_i,
  output logic [NUM_MASTERS-1:0] cbar_reqst_rdy_o,
  input  logic [ADDR_WIDTH-1:0]  cbar_reqst_data_i [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0] cbar_resp_val_o,
  input  logic [NUM_MASTERS-1:0] cbar_resp_rdy_i,
  output logic [RDATA_WIDTH-1:0] cbar_resp_data_o
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  rd_node_state_t         state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       ptr_after_grant;
  logic                   in_ar;
  logic                   in_r;
  logic                   r_ready;

  assign req   = cbar_reqst_val_i & CONNECTIVITY;
  assign in_ar = (state_q == RD_AR);
  assign in_r  = (state_q == RD_R);

  liteic_rr_arbiter #(
    .NUM_REQ (NUM_MASTERS)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  assign ptr_after_grant = (grant_idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                     : grant_idx_q + 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= RD_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    grant_idx_d      = grant_idx_q;
    rr_ptr_d         = rr_ptr_q;
    slv_axil.ar_valid = 1'b0;
    slv_axil.ar_addr  = '0;
    r_ready          = 1'b0;
    cbar_resp_data_o = '0;

    case (state_q)
      RD_IDLE: begin
        if (|req) begin
          grant_d     = arb_grant;
          grant_idx_d = arb_idx;
          state_d     = RD_AR;
        end
      end
      RD_AR: begin
        slv_axil.ar_valid = 1'b1;
        slv_axil.ar_addr  = cbar_reqst_data_i[grant_idx_q];
        if (slv_axil.ar_ready) state_d = RD_R;
      end
      RD_R: begin
        // Slave R is only consumed when the granted master can take it.
        r_ready          = |(grant_q & cbar_resp_rdy_i);
        cbar_resp_data_o = {slv_axil.r_data, slv_axil.r_resp};
        if (slv_axil.r_valid && r_ready) begin
          rr_ptr_d    = ptr_after_grant;
          grant_d     = '0;
          grant_idx_d = '0;
          state_d     = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign slv_axil.r_ready = r_ready;

  // State qualification keeps every non-granted (and every idle) lane at zero.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_lane
    assign cbar_reqst_rdy_o[gi] = in_ar & grant_q[gi] & slv_axil.ar_ready;
    assign cbar_resp_val_o[gi]  = in_r  & grant_q[gi] & slv_axil.r_valid;
  end

endmodule

// File: tb/tb_liteic_slave_node_read.sv
// Directed bench for liteic_slave_node_read with a service-order scoreboard.
module tb_liteic_slave_node_read;
  import liteic_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rstn_i;

  // Main DUT: 4 masters, fully connected
  axi_lite_if axil ();
  logic [3:0]  val, rdy, resp_val, resp_rdy;
  logic [31:0] addr [4];
  logic [33:0] resp_data;

  // Masked DUT: 3 masters, m1 disconnected
  axi_lite_if axil_m ();
  logic [2:0]  m_val, m_rdy, m_resp_val, m_resp_rdy;
  logic [31:0] m_addr [3];
  logic [33:0] m_resp_data;

  liteic_slave_node_read #(
    .NUM_MASTERS (4)
  ) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .slv_axil          (axil),
    .cbar_reqst_val_i  (val),
    .cbar_reqst_rdy_o  (rdy),
    .cbar_reqst_data_i (addr),
    .cbar_resp_val_o   (resp_val),
    .cbar_resp_rdy_i   (resp_rdy),
    .cbar_resp_data_o  (resp_data)
  );

  liteic_slave_node_read #(
    .NUM_MASTERS  (3),
    .CONNECTIVITY (3'b101)
  ) dut_m (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .slv_axil          (axil_m),
    .cbar_reqst_val_i  (m_val),
    .cbar_reqst_rdy_o  (m_rdy),
    .cbar_reqst_data_i (m_addr),
    .cbar_resp_val_o   (m_resp_val),
    .cbar_resp_rdy_i   (m_resp_rdy),
    .cbar_resp_data_o  (m_resp_data)
  );

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } sb_item_t;

  sb_item_t sb[$];
  int passed = 0;
  int total  = 0;
  int served [4];
  int last_m  = -1;
  int repeats = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic expect_txn(input int m, input logic [31:0] d, input logic [1:0] r);
    sb_item_t e;
    e.m    = m;
    e.addr = addr[m];
    e.data = d;
    e.resp = r;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
  endtask

  // Plays the AXI-Lite slave for one transaction and checks it against the scoreboard head.
  task automatic serve(input int ar_delay, input int stall, input bit keep);
    sb_item_t e;
    int n;
    int obs_m;
    n = 0;
    @(negedge clk_i);
    while (axil.ar_valid !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("ar_valid_seen", {63'd0, axil.ar_valid}, 64'd1);
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard_underflow: observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    chk("ar_addr", {32'd0, axil.ar_addr}, {32'd0, e.addr});
    repeat (ar_delay) begin
      chk("rdy_before_ar_ready", {60'd0, rdy}, 64'd0);
      @(negedge clk_i);
    end
    axil.ar_ready = 1'b1;
    #1;
    chk("rdy_onehot", {60'd0, rdy}, 64'd1 << e.m);
    obs_m = -1;
    for (int i = 0; i < 4; i++) if (rdy[i]) obs_m = i;
    if (obs_m >= 0) begin
      served[obs_m]++;
      if (obs_m == last_m) repeats++;
      last_m = obs_m;
    end
    @(posedge clk_i);
    #1;
    axil.ar_ready = 1'b0;
    if (!keep) val[e.m] = 1'b0;
    axil.r_valid = 1'b1;
    axil.r_data  = e.data;
    axil.r_resp  = e.resp;
    resp_rdy[e.m] = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_i);
      chk("bp_r_ready", {63'd0, axil.r_ready}, 64'd0);
      chk("bp_ar_valid", {63'd0, axil.ar_valid}, 64'd0);
      chk("bp_resp_val", {60'd0, resp_val}, 64'd1 << e.m);
      chk("bp_payload", {30'd0, resp_data}, {30'd0, e.data, e.resp});
    end
    @(negedge clk_i);
    resp_rdy[e.m] = 1'b1;
    #1;
    chk("resp_val_onehot", {60'd0, resp_val}, 64'd1 << e.m);
    chk("resp_data", {30'd0, resp_data}, {30'd0, e.data, e.resp});
    chk("r_ready", {63'd0, axil.r_ready}, 64'd1);
    chk("no_ar_in_r", {63'd0, axil.ar_valid}, 64'd0);
    @(posedge clk_i);
    #1 axil.r_valid = 1'b0;
    $display("txn master=%0d addr=%h data=%h resp=%0d", e.m, e.addr, e.data, e.resp);
  endtask

  initial begin
    int n;
    rstn_i        = 1'b0;
    val           = '0;
    resp_rdy      = '1;
    m_val         = '0;
    m_resp_rdy    = '1;
    for (int i = 0; i < 4; i++) addr[i] = '0;
    for (int i = 0; i < 3; i++) m_addr[i] = '0;
    for (int i = 0; i < 4; i++) served[i] = 0;
    axil.ar_ready = 1'b0;  axil.r_valid = 1'b0;  axil.r_data = '0;  axil.r_resp = '0;
    axil_m.ar_ready = 1'b0; axil_m.r_valid = 1'b0; axil_m.r_data = '0; axil_m.r_resp = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ar_valid", {63'd0, axil.ar_valid}, 64'd0);
    chk("rst_ar_addr", {32'd0, axil.ar_addr}, 64'd0);
    chk("rst_r_ready", {63'd0, axil.r_ready}, 64'd0);
    chk("rst_rdy", {60'd0, rdy}, 64'd0);
    chk("rst_resp_val", {60'd0, resp_val}, 64'd0);
    chk("rst_resp_data", {30'd0, resp_data}, 64'd0);
    @(posedge clk_i);
    #1 rstn_i = 1'b1;

    // Single read from m0
    addr[0] = 32'h0000_0100;
    val     = 4'b0001;
    expect_txn(0, 32'hDEAD_BEEF, 2'b00);
    serve(2, 0, 0);

    // Contention from reset: m0, m1, m2, then m0 before m2 after the pointer wraps
    do_reset();
    addr[0] = 32'h0000_1000; addr[1] = 32'h0000_1100; addr[2] = 32'h0000_1200;
    val = 4'b0111;
    expect_txn(0, 32'h1111_0000, 2'b00);
    expect_txn(1, 32'h1111_0001, 2'b10);
    expect_txn(2, 32'h1111_0002, 2'b00);
    repeat (3) serve(1, 0, 0);
    addr[0] = 32'h0000_1004; addr[2] = 32'h0000_1204;
    val = 4'b0101;
    expect_txn(0, 32'h2222_0000, 2'b00);
    expect_txn(2, 32'h2222_0002, 2'b11);
    repeat (2) serve(0, 0, 0);

    // Backpressure on m1 while m2 waits
    addr[1] = 32'h0000_0300; addr[2] = 32'h0000_0304;
    val = 4'b0110;
    expect_txn(1, 32'hBBBB_0001, 2'b00);
    expect_txn(2, 32'hBBBB_0002, 2'b00);
    serve(0, 5, 0);
    serve(0, 0, 0);

    // Spurious r_valid while idle
    axil.r_valid = 1'b1;
    axil.r_data  = 32'h5A5A_5A5A;
    repeat (3) begin
      @(negedge clk_i);
      chk("spurious_r_ready", {63'd0, axil.r_ready}, 64'd0);
      chk("spurious_resp_val", {60'd0, resp_val}, 64'd0);
    end
    axil.r_valid = 1'b0;

    // Reset while in R
    addr[0] = 32'h0000_0400;
    val     = 4'b0001;
    n = 0;
    @(negedge clk_i);
    while (axil.ar_valid !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
    chk("midrst_ar_valid", {63'd0, axil.ar_valid}, 64'd1);
    axil.ar_ready = 1'b1;
    @(posedge clk_i);
    #1;
    axil.ar_ready = 1'b0;
    axil.r_valid  = 1'b1;
    axil.r_data   = 32'hABAD_CAFE;
    resp_rdy      = 4'b0000;
    @(negedge clk_i);
    chk("midrst_in_r", {60'd0, resp_val}, 64'd1);
    rstn_i = 1'b0;
    #1;
    chk("midrst_ar_valid_low", {63'd0, axil.ar_valid}, 64'd0);
    chk("midrst_r_ready", {63'd0, axil.r_ready}, 64'd0);
    chk("midrst_rdy", {60'd0, rdy}, 64'd0);
    chk("midrst_resp_val", {60'd0, resp_val}, 64'd0);
    chk("midrst_resp_data", {30'd0, resp_data}, 64'd0);
    axil.r_valid = 1'b0;
    resp_rdy     = '1;
    val          = '0;
    @(posedge clk_i);
    #1 rstn_i = 1'b1;
    addr[1] = 32'h0000_0500;
    val     = 4'b0010;
    expect_txn(1, 32'h0F0F_0F0F, 2'b00);
    serve(0, 0, 0);

    // Masked master on the 3-master node
    m_addr[1] = 32'h0000_0700; m_addr[2] = 32'h0000_0800;
    m_val = 3'b010;
    repeat (20) begin
      @(negedge clk_i);
      chk("mask_ar_valid", {63'd0, axil_m.ar_valid}, 64'd0);
      chk("mask_rdy", {61'd0, m_rdy}, 64'd0);
    end
    m_val = 3'b110;
    n = 0;
    while (axil_m.ar_valid !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
    chk("mask_m2_ar_addr", {32'd0, axil_m.ar_addr}, 64'h800);
    axil_m.ar_ready = 1'b1;
    #1;
    chk("mask_m2_rdy", {61'd0, m_rdy}, 64'b100);
    @(posedge clk_i);
    #1;
    axil_m.ar_ready = 1'b0;
    m_val           = 3'b000;
    axil_m.r_valid  = 1'b1;
    axil_m.r_data   = 32'h7777_0002;
    @(negedge clk_i);
    chk("mask_m2_resp_val", {61'd0, m_resp_val}, 64'b100);
    @(posedge clk_i);
    #1 axil_m.r_valid = 1'b0;

    // Fairness soak: all four masters keep requesting
    do_reset();
    for (int i = 0; i < 4; i++) begin
      addr[i]   = 32'h0000_2000 + 32'(i * 16);
      served[i] = 0;
    end
    last_m  = -1;
    repeats = 0;
    val = 4'b1111;
    for (int t = 0; t < 400; t++) begin
      expect_txn(t % 4, 32'hC0DE_0000 + 32'(t), (t % 3 == 0) ? 2'b10 : 2'b00);
      serve(t % 2, 0, 1);
    end
    val = '0;
    for (int i = 0; i < 4; i++) chk($sformatf("soak_served_m%0d", i), 64'(served[i]), 64'd100);
    chk("soak_back_to_back", 64'(repeats), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
